// File: rtl/vga_csr_fetch_pkg.sv
// Shared definitions for the VGA CSR read master: bus widths, FSM encoding
// and the response-queue entry layout.
package vga_csr_fetch_pkg;

    localparam int unsigned VGA_CSR_AW = 17;
    localparam int unsigned VGA_CSR_DW = 16;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_BUS  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic                  err;
        logic [VGA_CSR_DW-1:0] dat;
    } rsp_entry_t;

endpackage

// File: rtl/vga_csr_fetch_rspq.sv
// In-order response queue: DEPTH entries of {err, data}, synchronous clear,
// occupancy zero-extended to 5 bits.
module vga_csr_fetch_rspq
    import vga_csr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output rsp_entry_t head,
    output logic       valid,
    output logic [4:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q;
    rsp_entry_t    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign do_push = push && (cnt_q != (PW+1)'(DEPTH));
    assign do_pop  = pop && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign valid = (cnt_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : '0;
    assign level = 5'(cnt_q);

endmodule

// File: rtl/vga_csr_fetch.sv
// CSR read master: one outstanding cyc/stb/ack read at a time, bounded by a
// timeout, with results returned in order through the response queue.
module vga_csr_fetch
    import vga_csr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VGA_CSR_AW-1:0] seq_adr_i,
    input  logic                  seq_stb_i,
    output logic                  seq_stall_o,
    output logic [VGA_CSR_DW-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_pop_i,
    output logic [4:0]            rsp_level_o,
    output logic [VGA_CSR_AW-1:0] csr_adr_o,
    output logic                  csr_cyc_o,
    output logic                  csr_stb_o,
    input  logic [VGA_CSR_DW-1:0] csr_dat_i,
    input  logic                  csr_ack_i,
    output logic                  timeout_sticky_o
);

    fetch_state_e          state_q, state_d;
    logic [VGA_CSR_AW-1:0] adr_q, adr_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  sticky_q, sticky_d;
    logic                  rsp_push;
    rsp_entry_t            push_data;
    rsp_entry_t            head;

    assign seq_stall_o = (state_q == FETCH_BUS) || (rsp_level_o == 5'(DEPTH));

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        tmo_d     = tmo_q;
        sticky_d  = sticky_q;
        rsp_push  = 1'b0;
        push_data = '0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (seq_stb_i && !seq_stall_o) begin
                    adr_d   = seq_adr_i;
                    tmo_d   = '0;
                    state_d = FETCH_BUS;
                end
            end
            FETCH_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (csr_ack_i) begin
                    rsp_push  = 1'b1;
                    push_data = '{err: 1'b0, dat: csr_dat_i};
                    state_d   = FETCH_IDLE;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    rsp_push  = 1'b1;
                    push_data = '{err: 1'b1, dat: '0};
                    sticky_d  = 1'b1;
                    state_d   = FETCH_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_IDLE;
            adr_q    <= '0;
            tmo_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            tmo_q    <= tmo_d;
            sticky_q <= sticky_d;
        end
    end

    vga_csr_fetch_rspq #(
        .DEPTH(DEPTH)
    ) u_rspq (
        .clk      (clk),
        .clr      (rst),
        .push     (rsp_push),
        .push_data(push_data),
        .pop      (rsp_pop_i),
        .head     (head),
        .valid    (rsp_valid_o),
        .level    (rsp_level_o)
    );

    assign csr_adr_o        = adr_q;
    assign csr_cyc_o        = (state_q == FETCH_BUS);
    assign csr_stb_o        = csr_cyc_o;
    assign rsp_dat_o        = head.dat;
    assign rsp_err_o        = head.err;
    assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_vga_csr_fetch.sv
// Directed bench for vga_csr_fetch: zero-wait, delayed, timeout, queue-full,
// mid-read reset and ack-on-last-cycle scenarios against hand-computed values.
module tb_vga_csr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] seq_adr_i;
    logic        seq_stb_i;
    logic        seq_stall_o;
    logic [15:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_valid_o;
    logic        rsp_pop_i;
    logic [4:0]  rsp_level_o;
    logic [16:0] csr_adr_o;
    logic        csr_cyc_o;
    logic        csr_stb_o;
    logic [15:0] csr_dat_i;
    logic        csr_ack_i;
    logic        timeout_sticky_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_csr_fetch #(
        .DEPTH  (4),
        .TIMEOUT(15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .seq_adr_i       (seq_adr_i),
        .seq_stb_i       (seq_stb_i),
        .seq_stall_o     (seq_stall_o),
        .rsp_dat_o       (rsp_dat_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_pop_i       (rsp_pop_i),
        .rsp_level_o     (rsp_level_o),
        .csr_adr_o       (csr_adr_o),
        .csr_cyc_o       (csr_cyc_o),
        .csr_stb_o       (csr_stb_o),
        .csr_dat_i       (csr_dat_i),
        .csr_ack_i       (csr_ack_i),
        .timeout_sticky_o(timeout_sticky_o)
    );

    // A push into a full queue must never occur.
    always @(posedge clk) begin
        if (!rst && dut.rsp_push && rsp_level_o == 5'd4) begin
            failures++;
            $display("FAIL push_when_full observed=1 expected=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; caller guarantees the block is idle.
    task automatic req(input logic [16:0] adr);
        seq_adr_i = adr;
        seq_stb_i = 1'b1;
        tick();
        seq_stb_i = 1'b0;
    endtask

    task automatic zero_wait(input logic [16:0] adr, input logic [15:0] dat);
        req(adr);
        chk("zw_cyc", 32'(csr_cyc_o), 32'd1);
        chk("zw_stb", 32'(csr_stb_o), 32'd1);
        chk("zw_adr", 32'(csr_adr_o), 32'(adr));
        chk("zw_stall_bus", 32'(seq_stall_o), 32'd1);
        csr_dat_i = dat;
        csr_ack_i = 1'b1;
        tick();
        csr_ack_i = 1'b0;
        chk("zw_cyc_low", 32'(csr_cyc_o), 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic err, input logic [15:0] dat);
        chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_err"}, 32'(rsp_err_o), 32'(err));
        chk({tag, "_dat"}, 32'(rsp_dat_o), 32'(dat));
        rsp_pop_i = 1'b1;
        tick();
        rsp_pop_i = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        seq_adr_i = '0;
        seq_stb_i = 1'b0;
        rsp_pop_i = 1'b0;
        csr_dat_i = '0;
        csr_ack_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_cyc", 32'(csr_cyc_o), 32'd0);
        chk("rst_stb", 32'(csr_stb_o), 32'd0);
        chk("rst_adr", 32'(csr_adr_o), 32'd0);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_level", 32'(rsp_level_o), 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_dat", 32'(rsp_dat_o), 32'd0);
        chk("rst_sticky", 32'(timeout_sticky_o), 32'd0);
        chk("rst_stall", 32'(seq_stall_o), 32'd0);

        // Zero-wait reads
        zero_wait(17'h00010, 16'h1234);
        chk("zw1_valid", 32'(rsp_valid_o), 32'd1);
        chk("zw1_dat", 32'(rsp_dat_o), 32'h1234);
        chk("zw1_stall_idle", 32'(seq_stall_o), 32'd0);
        zero_wait(17'h00011, 16'hABCD);
        zero_wait(17'h00012, 16'h0F0F);
        chk("zw_level3", 32'(rsp_level_o), 32'd3);
        pop_expect("zw_pop0", 1'b0, 16'h1234);
        pop_expect("zw_pop1", 1'b0, 16'hABCD);
        pop_expect("zw_pop2", 1'b0, 16'h0F0F);
        chk("zw_empty", 32'(rsp_valid_o), 32'd0);

        // Ack delayed by 5 cycles: 6 strobe cycles with a stable address
        req(17'h1ABCD);
        for (int k = 0; k < 5; k++) begin
            chk("dl_cyc", 32'(csr_stb_o), 32'd1);
            chk("dl_adr", 32'(csr_adr_o), 32'h1ABCD);
            chk("dl_novalid", 32'(rsp_valid_o), 32'd0);
            tick();
        end
        chk("dl_cyc6", 32'(csr_stb_o), 32'd1);
        chk("dl_adr6", 32'(csr_adr_o), 32'h1ABCD);
        csr_dat_i = 16'h5555;
        csr_ack_i = 1'b1;
        tick();
        csr_ack_i = 1'b0;
        chk("dl_cyc_low", 32'(csr_cyc_o), 32'd0);
        pop_expect("dl_pop", 1'b0, 16'h5555);

        // No ack: abort after exactly 15 strobe cycles
        req(17'h00100);
        n = 0;
        while (csr_stb_o && n < 20) begin
            n++;
            tick();
        end
        chk("to_stb_cycles", 32'(n), 32'd15);
        chk("to_level", 32'(rsp_level_o), 32'd1);
        chk("to_sticky", 32'(timeout_sticky_o), 32'd1);
        chk("to_err_head", 32'(rsp_err_o), 32'd1);
        tick();
        csr_dat_i = 16'hDEAD;
        csr_ack_i = 1'b1;
        tick();
        csr_ack_i = 1'b0;
        chk("late_ack_level", 32'(rsp_level_o), 32'd1);
        chk("late_ack_cyc", 32'(csr_cyc_o), 32'd0);
        pop_expect("to_pop", 1'b1, 16'h0000);
        chk("to_sticky_hold", 32'(timeout_sticky_o), 32'd1);

        // Fill the queue, then exercise pop / pop+push / empty pop
        for (int i = 0; i < 4; i++) zero_wait(17'(17'h00200 + i), 16'(16'h1000 + i));
        chk("full_level", 32'(rsp_level_o), 32'd4);
        chk("full_stall", 32'(seq_stall_o), 32'd1);
        seq_adr_i = 17'h00300;
        seq_stb_i = 1'b1;
        rsp_pop_i = 1'b1;
        tick();
        rsp_pop_i = 1'b0;
        chk("full_not_accepted", 32'(csr_cyc_o), 32'd0);
        chk("pop_level3", 32'(rsp_level_o), 32'd3);
        chk("pop_stall_low", 32'(seq_stall_o), 32'd0);
        chk("pop_head", 32'(rsp_dat_o), 32'h1001);
        tick();
        seq_stb_i = 1'b0;
        chk("fill_bus", 32'(csr_cyc_o), 32'd1);
        chk("fill_adr", 32'(csr_adr_o), 32'h00300);
        csr_dat_i = 16'h2000;
        csr_ack_i = 1'b1;
        rsp_pop_i = 1'b1;
        tick();
        csr_ack_i = 1'b0;
        rsp_pop_i = 1'b0;
        chk("pushpop_level", 32'(rsp_level_o), 32'd3);
        pop_expect("fq_pop0", 1'b0, 16'h1002);
        pop_expect("fq_pop1", 1'b0, 16'h1003);
        pop_expect("fq_pop2", 1'b0, 16'h2000);
        rsp_pop_i = 1'b1;
        tick();
        rsp_pop_i = 1'b0;
        chk("empty_pop_level", 32'(rsp_level_o), 32'd0);
        chk("empty_pop_valid", 32'(rsp_valid_o), 32'd0);

        // Reset during BUS cycle 3 with a queued entry and a coincident ack
        zero_wait(17'h00400, 16'h7777);
        req(17'h00401);
        tick();
        tick();
        chk("rb_bus3", 32'(csr_cyc_o), 32'd1);
        rst = 1'b1;
        csr_dat_i = 16'h9999;
        csr_ack_i = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_cyc", 32'(csr_cyc_o), 32'd0);
        chk("rb_stb", 32'(csr_stb_o), 32'd0);
        chk("rb_level", 32'(rsp_level_o), 32'd0);
        chk("rb_valid", 32'(rsp_valid_o), 32'd0);
        chk("rb_sticky", 32'(timeout_sticky_o), 32'd0);
        tick();
        csr_ack_i = 1'b0;
        chk("rb_ack_ignored", 32'(rsp_level_o), 32'd0);
        chk("rb_still_idle", 32'(csr_cyc_o), 32'd0);

        // Ack on the 15th strobe cycle wins over the timeout
        req(17'h00500);
        for (int k = 0; k < 14; k++) tick();
        chk("ackto_bus15", 32'(csr_stb_o), 32'd1);
        csr_dat_i = 16'hBEEF;
        csr_ack_i = 1'b1;
        tick();
        csr_ack_i = 1'b0;
        chk("ackto_cyc", 32'(csr_cyc_o), 32'd0);
        chk("ackto_level", 32'(rsp_level_o), 32'd1);
        chk("ackto_sticky", 32'(timeout_sticky_o), 32'd0);
        tick();
        chk("ackto_level_hold", 32'(rsp_level_o), 32'd1);
        pop_expect("ackto_pop", 1'b0, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
